// File: rtl/alu_disp_pkg.sv
// Shared constants and types for the ALU result display stage.
package alu_disp_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_R     = 7'h2F;

    // Active-low 7-segment patterns, entry n is the glyph for hex digit n.
    localparam logic [15:0][6:0] SEG_HEX = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] HEX_E  = 4'hE;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment decoder.
module hex_to_seg7
    import alu_disp_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg_c
);

    assign seg_c = SEG_HEX[digit];

endmodule

// File: rtl/alu_result_display.sv
// Debounced capture of ALU result/opcode and 4-digit multiplexed 7-segment driver
// with a blinking "Er" indication for the add/sub error sentinel.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int unsigned REFRESH_DIV   = 50000,
    parameter int unsigned STABLE_CYCLES = 500000,
    parameter int unsigned BLINK_DIV     = 25000000,
    parameter logic [7:0]  ERR_CODE      = 8'hEE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in_result,
    input  logic [3:0] in_btn,
    output logic [6:0] seg_n,
    output logic       dp_n,
    output logic [3:0] an_n,
    output logic       result_valid
);

    localparam int unsigned RW = (REFRESH_DIV   > 1) ? $clog2(REFRESH_DIV)   : 1;
    localparam int unsigned SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_DIV     > 1) ? $clog2(BLINK_DIV)     : 1;

    logic [11:0]   sync1_q, sync2_q, smp_prev_q;
    logic [SW-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]    shown_res_q, shown_res_d;
    logic [3:0]    shown_op_q, shown_op_d;
    logic          result_valid_q, result_valid_d;
    logic [RW-1:0] refresh_cnt_q, refresh_cnt_d;
    digit_idx_t    idx_q, idx_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic [6:0]    seg_n_q, seg_n_d;
    logic          dp_n_q, dp_n_d;
    logic [3:0]    an_n_q, an_n_d;

    logic [11:0]   smp;
    logic          stable, hold_full, load, err_q, err_d;
    logic [6:0]    hex_lo_c, hex_hi_c, hex_op_c;

    assign smp = sync2_q;

    // Debounce: a value must repeat for the whole window and differ from what is shown.
    always_comb begin
        stable         = (smp == smp_prev_q);
        hold_full      = (hold_cnt_q == SW'(STABLE_CYCLES - 1));
        load           = stable && hold_full && (smp != {~shown_op_q, shown_res_q});
        hold_cnt_d     = hold_cnt_q;
        shown_res_d    = shown_res_q;
        shown_op_d     = shown_op_q;
        result_valid_d = 1'b0;
        if (!stable) begin
            hold_cnt_d = '0;
        end else if (!hold_full) begin
            hold_cnt_d = hold_cnt_q + SW'(1);
        end
        if (load) begin
            shown_op_d     = ~smp[11:8];
            shown_res_d    = smp[7:0];
            result_valid_d = 1'b1;
        end
    end

    assign err_q = (shown_res_q == ERR_CODE) && ((shown_op_q == OP_ADD) || (shown_op_q == OP_SUB));
    assign err_d = (shown_res_d == ERR_CODE) && ((shown_op_d == OP_ADD) || (shown_op_d == OP_SUB));

    // Digit scan and error blink timing.
    always_comb begin
        refresh_cnt_d = refresh_cnt_q + RW'(1);
        idx_d         = idx_q;
        blink_cnt_d   = '0;
        blink_on_d    = 1'b1;
        if (refresh_cnt_q == RW'(REFRESH_DIV - 1)) begin
            refresh_cnt_d = '0;
            idx_d         = idx_q + digit_idx_t'(1);
        end
        if (!load && err_q) begin
            blink_on_d  = blink_on_q;
            blink_cnt_d = blink_cnt_q + BW'(1);
            if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end
        end
    end

    hex_to_seg7 u_hex_lo (.digit(shown_res_d[3:0]), .seg_c(hex_lo_c));
    hex_to_seg7 u_hex_hi (.digit(shown_res_d[7:4]), .seg_c(hex_hi_c));
    hex_to_seg7 u_hex_op (.digit(shown_op_d),       .seg_c(hex_op_c));

    // Next display outputs, built from the post-edge digit index and shown value.
    always_comb begin
        seg_n_d = SEG_BLANK;
        dp_n_d  = (idx_d != digit_idx_t'(2));
        an_n_d  = ~(4'b0001 << idx_d);
        case (idx_d)
            2'd0:    seg_n_d = err_d ? (blink_on_d ? SEG_R : SEG_BLANK) : hex_lo_c;
            2'd1:    seg_n_d = err_d ? (blink_on_d ? SEG_HEX[HEX_E] : SEG_BLANK) : hex_hi_c;
            2'd2:    seg_n_d = SEG_BLANK;
            default: seg_n_d = hex_op_c;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            smp_prev_q     <= '0;
            hold_cnt_q     <= '0;
            shown_res_q    <= '0;
            shown_op_q     <= '0;
            result_valid_q <= 1'b0;
            refresh_cnt_q  <= '0;
            idx_q          <= '0;
            blink_cnt_q    <= '0;
            blink_on_q     <= 1'b1;
            seg_n_q        <= SEG_BLANK;
            dp_n_q         <= 1'b1;
            an_n_q         <= 4'hF;
        end else begin
            sync1_q        <= {in_btn, in_result};
            sync2_q        <= sync1_q;
            smp_prev_q     <= smp;
            hold_cnt_q     <= hold_cnt_d;
            shown_res_q    <= shown_res_d;
            shown_op_q     <= shown_op_d;
            result_valid_q <= result_valid_d;
            refresh_cnt_q  <= refresh_cnt_d;
            idx_q          <= idx_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_on_q     <= blink_on_d;
            seg_n_q        <= seg_n_d;
            dp_n_q         <= dp_n_d;
            an_n_q         <= an_n_d;
        end
    end

    assign seg_n        = seg_n_q;
    assign dp_n         = dp_n_q;
    assign an_n         = an_n_q;
    assign result_valid = result_valid_q;

endmodule

// File: tb/tb_alu_result_display.sv
// Directed self-checking bench for alu_result_display with short timing parameters.
module tb_alu_result_display;

    localparam int unsigned REFRESH = 4;
    localparam int unsigned STABLE  = 8;
    localparam int unsigned BLINK   = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_result;
    logic [3:0] in_btn;
    logic [6:0] seg_n;
    logic       dp_n;
    logic [3:0] an_n;
    logic       result_valid;

    int vectors = 0;
    int miscompares = 0;

    alu_result_display #(
        .REFRESH_DIV(REFRESH), .STABLE_CYCLES(STABLE), .BLINK_DIV(BLINK), .ERR_CODE(8'hEE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_result(in_result), .in_btn(in_btn),
        .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n), .result_valid(result_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] hexs(input logic [3:0] d);
        case (d)
            4'h0: return 7'h40; 4'h1: return 7'h79; 4'h2: return 7'h24; 4'h3: return 7'h30;
            4'h4: return 7'h19; 4'h5: return 7'h12; 4'h6: return 7'h02; 4'h7: return 7'h78;
            4'h8: return 7'h00; 4'h9: return 7'h10; 4'hA: return 7'h08; 4'hB: return 7'h03;
            4'hC: return 7'h46; 4'hD: return 7'h21; 4'hE: return 7'h06; default: return 7'h0E;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " seg"}, 32'(seg_n), 32'h7F);
        chk({tag, " dp"}, 32'(dp_n), 32'h1);
        chk({tag, " an"}, 32'(an_n), 32'hF);
        chk({tag, " rv"}, 32'(result_valid), 32'h0);
    endtask

    task automatic wait_pulse(input string tag, input int max_cycles);
        bit got;
        got = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk({tag, " pulse"}, 32'(got), 32'h1);
    endtask

    task automatic count_pulses(input int n, output int cnt);
        cnt = 0;
        repeat (n) begin
            @(negedge clk);
            if (result_valid === 1'b1) cnt++;
        end
    endtask

    // Checks n consecutive samples (starting with the current one) against the expected scan.
    task automatic scan_check(input string tag, input int n, input logic [7:0] res,
                              input logic [3:0] op, input bit blink);
        logic [3:0] prev_an;
        int run;
        bit first;
        prev_an = an_n;
        run = 0;
        first = 1'b1;
        for (int i = 0; i < n; i++) begin
            logic [6:0] es;
            logic ed;
            bit on;
            on = !blink || (((i / BLINK) % 2) == 0);
            es = 7'h7F;
            ed = 1'b1;
            case (an_n)
                4'b1110: es = blink ? (on ? 7'h2F : 7'h7F) : hexs(res[3:0]);
                4'b1101: es = blink ? (on ? 7'h06 : 7'h7F) : hexs(res[7:4]);
                4'b1011: ed = 1'b0;
                4'b0111: es = hexs(op);
                default: ;
            endcase
            chk({tag, " an onehot"}, 32'($countones(~an_n)), 32'h1);
            chk({tag, " seg"}, 32'(seg_n), 32'(es));
            chk({tag, " dp"}, 32'(dp_n), 32'(ed));
            if (i > 0) chk({tag, " rv"}, 32'(result_valid), 32'h0);
            if (an_n != prev_an) begin
                if (!first) chk({tag, " run"}, 32'(run), 32'(REFRESH));
                chk({tag, " rot"}, 32'(an_n), 32'({prev_an[2:0], prev_an[3]}));
                first = 1'b0;
                run = 1;
                prev_an = an_n;
            end else begin
                run++;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt, total;

        // Reset held
        rst_n = 1'b0;
        in_result = 8'h00;
        in_btn = 4'hF;
        repeat (3) @(negedge clk);
        chk_reset("reset held");
        rst_n = 1'b1;

        // Add opcode, result 3C
        @(negedge clk);
        in_result = 8'h3C;
        in_btn = 4'b1101;
        wait_pulse("t2 load", 40);
        scan_check("t2 scan", 40, 8'h3C, 4'h2, 1'b0);

        // Bouncing input never settles: no load, old value kept
        total = 0;
        for (int k = 0; k < 6; k++) begin
            in_result = (k % 2 == 1) ? 8'hAA : 8'h55;
            count_pulses(4, cnt);
            total += cnt;
        end
        chk("t3 bounce pulses", 32'(total), 32'h0);
        for (int k = 6; k < 10; k++) begin
            in_result = (k % 2 == 1) ? 8'hAA : 8'h55;
            scan_check("t3 keep", 4, 8'h3C, 4'h2, 1'b0);
        end
        wait_pulse("t3 load AA", 40);
        scan_check("t3 scan", 32, 8'hAA, 4'h2, 1'b0);

        // Error sentinel under add blinks, under op7 is plain hex
        in_result = 8'hEE;
        wait_pulse("t4 load err", 40);
        scan_check("t4 blink", 48, 8'hEE, 4'h2, 1'b1);
        in_btn = 4'b1000;
        wait_pulse("t4 load op7", 40);
        scan_check("t4 op7", 48, 8'hEE, 4'h7, 1'b0);

        // Unchanged stable value never re-pulses; opcode-only change loads
        in_result = 8'hAA;
        wait_pulse("t5 load AA", 40);
        scan_check("t5 hold", 32, 8'hAA, 4'h7, 1'b0);
        count_pulses(30, cnt);
        chk("t5 no repulse", 32'(cnt), 32'h0);
        in_btn = 4'b1100;
        wait_pulse("t5 op change", 40);
        scan_check("t5 op3", 32, 8'hAA, 4'h3, 1'b0);

        // Asynchronous reset mid-scan
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_reset("reset async");
        @(negedge clk);
        chk_reset("reset async held");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
